// File: rtl/pipeline_hazard_ctrl_if.sv
// Decoder-side bundle for the pipeline hazard controller.
// The decoder/driver takes the master modport; the controller takes the slave modport.
interface pipeline_hazard_ctrl_if;
  logic        id_valid_i;
  logic [4:0]  id_src1_i;
  logic [4:0]  id_src2_i;
  logic [4:0]  id_src3_i;
  logic        id_psw_rd_i;
  logic [4:0]  id_dst_i;
  logic [4:0]  id_dst2_i;
  logic        id_psw_wr_i;
  logic        ex_branch_i;
  logic        mem_busy_i;
  logic        issue_o;
  logic        stall_o;
  logic        flush_o;
  logic        pipe_en_o;
  logic [15:0] stall_cnt_o;

  modport master (
    output id_valid_i, id_src1_i, id_src2_i, id_src3_i, id_psw_rd_i,
           id_dst_i, id_dst2_i, id_psw_wr_i, ex_branch_i, mem_busy_i,
    input  issue_o, stall_o, flush_o, pipe_en_o, stall_cnt_o
  );

  modport slave (
    input  id_valid_i, id_src1_i, id_src2_i, id_src3_i, id_psw_rd_i,
           id_dst_i, id_dst2_i, id_psw_wr_i, ex_branch_i, mem_busy_i,
    output issue_o, stall_o, flush_o, pipe_en_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage issue control for the IF->ID->EX->MEM->WB pipeline: RAW/PSW hazard
// stall, memory-wait freeze, and branch flush with a refill window.
module pipeline_hazard_ctrl #(
  parameter int unsigned PIPE_DEPTH    = 3,
  parameter int unsigned WB_BYPASS     = 1,
  parameter int unsigned REFILL_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned REG_W     = 5;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned STALL_W   = 16;
  // With write-back bypass the WB stage result is already visible to ID.
  localparam int unsigned CHK_DEPTH = (WB_BYPASS != 0) ? PIPE_DEPTH - 1 : PIPE_DEPTH;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic [REG_W-1:0] dst2;
    logic             psw_wr;
  } tag_t;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_REFILL = 1'b1
  } state_e;

  tag_t               tag_q [PIPE_DEPTH];
  tag_t               new_tag;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic               freeze_c;
  logic               hazard_c;
  logic               run_c;
  logic               flush_c;
  logic               issue_c;
  logic               stall_c;

  function automatic logic src_hit(input logic [REG_W-1:0] src, input tag_t t);
    return (src != '0) && t.valid && ((src == t.dst) || (src == t.dst2));
  endfunction

  assign freeze_c = bus.mem_busy_i;

  assign new_tag.valid  = 1'b1;
  assign new_tag.dst    = bus.id_dst_i;
  assign new_tag.dst2   = bus.id_dst2_i;
  assign new_tag.psw_wr = bus.id_psw_wr_i;

  // Read-after-write check against the in-flight producers that ID cannot yet see.
  always_comb begin
    hazard_c = 1'b0;
    for (int unsigned k = 0; k < CHK_DEPTH; k++) begin
      hazard_c = hazard_c
               | src_hit(bus.id_src1_i, tag_q[k])
               | src_hit(bus.id_src2_i, tag_q[k])
               | src_hit(bus.id_src3_i, tag_q[k])
               | (bus.id_psw_rd_i & tag_q[k].valid & tag_q[k].psw_wr);
    end
  end

  // Issue FSM: RUN issues, REFILL blocks issue while the front end refetches.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_c   = 1'b0;
    flush_c = 1'b0;
    case (state_q)
      ST_RUN: begin
        run_c = 1'b1;
        if (bus.ex_branch_i && !freeze_c) begin
          flush_c = 1'b1;
          cnt_d   = CNT_W'(REFILL_CYCLES);
          state_d = ST_REFILL;
        end
      end
      ST_REFILL: begin
        if (!freeze_c) begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_RUN;
          end
        end
      end
    endcase
  end

  // Outputs are forced to their reset values while rst_n is held low.
  assign issue_c = rst_n & bus.id_valid_i & run_c & ~hazard_c & ~freeze_c & ~bus.ex_branch_i;
  assign stall_c = rst_n & bus.id_valid_i & ~issue_c;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + STALL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      cnt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Tag shift register: a bubble enters EX whenever nothing issues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < PIPE_DEPTH; k++) begin
        tag_q[k] <= tag_t'('0);
      end
    end else if (!freeze_c) begin
      tag_q[0] <= issue_c ? new_tag : tag_t'('0);
      for (int unsigned k = 1; k < PIPE_DEPTH; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign bus.issue_o     = issue_c;
  assign bus.stall_o     = stall_c;
  assign bus.flush_o     = rst_n & flush_c;
  assign bus.pipe_en_o   = ~freeze_c | ~rst_n;
  assign bus.stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus random
// traffic, compared against an age-based in-flight instruction model.
module tb_pipeline_hazard_ctrl;

  localparam int DEPTH  = 3;
  localparam int CHK    = 2;
  localparam int REFILL = 2;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  pipeline_hazard_ctrl_if bus ();

  pipeline_hazard_ctrl #(
    .PIPE_DEPTH   (DEPTH),
    .WB_BYPASS    (1),
    .REFILL_CYCLES(REFILL)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: each issued instruction carries an age = non-frozen edges since issue.
  // Age 1 is EX, 2 is MEM, 3 is WB; ages 1..CHK are visible to the hazard check.
  typedef struct {
    logic [4:0] dst;
    logic [4:0] dst2;
    logic       psw;
    int         age;
  } ent_t;

  ent_t        inflight[$];
  int          refill_left;
  logic [15:0] m_cnt;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic m_hazard(input logic [4:0] s1, input logic [4:0] s2,
                                    input logic [4:0] s3, input logic prd);
    logic h;
    logic [4:0] srcs [3];
    h = 1'b0;
    srcs[0] = s1; srcs[1] = s2; srcs[2] = s3;
    foreach (inflight[i]) begin
      if (inflight[i].age <= CHK) begin
        for (int j = 0; j < 3; j++) begin
          if (srcs[j] != 5'd0 && (srcs[j] == inflight[i].dst || srcs[j] == inflight[i].dst2))
            h = 1'b1;
        end
        if (prd && inflight[i].psw) h = 1'b1;
      end
    end
    return h;
  endfunction

  task automatic model_reset();
    inflight.delete();
    refill_left = 0;
    m_cnt = 16'd0;
  endtask

  // One clock: drive at posedge+1, check at posedge+3, then advance the model at the edge.
  task automatic cycle(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] s3, input logic prd, input logic [4:0] d,
                       input logic [4:0] d2, input logic pwr, input logic br,
                       input logic busy);
    logic e_issue, e_stall, e_flush, haz;
    bus.id_valid_i  = v;
    bus.id_src1_i   = s1;
    bus.id_src2_i   = s2;
    bus.id_src3_i   = s3;
    bus.id_psw_rd_i = prd;
    bus.id_dst_i    = d;
    bus.id_dst2_i   = d2;
    bus.id_psw_wr_i = pwr;
    bus.ex_branch_i = br;
    bus.mem_busy_i  = busy;
    #2;
    haz     = m_hazard(s1, s2, s3, prd);
    e_flush = br && !busy && (refill_left == 0);
    e_issue = v && (refill_left == 0) && !haz && !busy && !br;
    e_stall = v && !e_issue;
    check("issue",     16'(bus.issue_o),   16'(e_issue));
    check("stall",     16'(bus.stall_o),   16'(e_stall));
    check("flush",     16'(bus.flush_o),   16'(e_flush));
    check("pipe_en",   16'(bus.pipe_en_o), 16'(!busy));
    check("stall_cnt", bus.stall_cnt_o,    m_cnt);
    @(posedge clk);
    if (e_stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (!busy) begin
      foreach (inflight[i]) inflight[i].age++;
      for (int i = inflight.size() - 1; i >= 0; i--) begin
        if (inflight[i].age > DEPTH) inflight.delete(i);
      end
      if (e_issue) inflight.push_back('{dst: d, dst2: d2, psw: pwr, age: 1});
    end
    if (e_flush) refill_left = REFILL;
    else if (!busy && refill_left > 0) refill_left--;
    #1;
  endtask

  task automatic idle();
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    rst_n = 1'b0;
    bus.id_valid_i = 1'b1; bus.id_src1_i = 5'd0; bus.id_src2_i = 5'd0; bus.id_src3_i = 5'd0;
    bus.id_psw_rd_i = 1'b0; bus.id_dst_i = 5'd0; bus.id_dst2_i = 5'd0; bus.id_psw_wr_i = 1'b0;
    bus.ex_branch_i = 1'b1; bus.mem_busy_i = 1'b1;

    // Outputs at reset, with active inputs held on the bus
    #12;
    check("rst_issue",   16'(bus.issue_o),   16'd0);
    check("rst_stall",   16'(bus.stall_o),   16'd0);
    check("rst_flush",   16'(bus.flush_o),   16'd0);
    check("rst_pipe_en", 16'(bus.pipe_en_o), 16'd1);
    check("rst_cnt",     bus.stall_cnt_o,    16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // r0 / no-destination back-to-back: never stalls
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // RAW on GR5: two stall cycles, issue on the third
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd5, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("raw_cnt", bus.stall_cnt_o, 16'd2);

    // dst==dst2 producer, consumer reads through src3; same-reg src/dst consumer
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd3, 5'd3, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd0, 5'd0, 5'd3, 1'b0, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    idle(); idle(); idle();

    // Taken branch: flush that cycle, issue blocked for 1+REFILL cycles
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Freeze with dst=7 in EX; consumer waits out freeze plus two live cycles
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd7, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd7, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Branch during freeze only flushes on release
    for (int i = 0; i < 2; i++) cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0);

    // Randomized traffic over a small register range to provoke overlaps
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) == 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) == 0));
    end

    // Reset mid-traffic: outputs drop immediately and in-flight tags are gone
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0);
    bus.id_src1_i = 5'd9; bus.id_psw_rd_i = 1'b1; bus.ex_branch_i = 1'b1; bus.mem_busy_i = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_issue",   16'(bus.issue_o),   16'd0);
    check("mid_rst_stall",   16'(bus.stall_o),   16'd0);
    check("mid_rst_flush",   16'(bus.flush_o),   16'd0);
    check("mid_rst_pipe_en", 16'(bus.pipe_en_o), 16'd1);
    check("mid_rst_cnt",     bus.stall_cnt_o,    16'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 5'd9, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

    // Long freeze with a waiting instruction drives the counter into saturation
    for (int i = 0; i < 65540; i++) cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
    check("sat_cnt", bus.stall_cnt_o, 16'hFFFF);

    // PSW write then PSW read: two stalls; counter stays saturated
    cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("psw_sat_cnt", bus.stall_cnt_o, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
